// File: rtl/word_counter_pkg.sv
// -----------------------------------------------------------------------------
// word_counter_pkg
// Shared constants for the word_counter block: the Word interconnect word
// width and the 2-bit terminal-count mode encodings presented on Mode_i.
// -----------------------------------------------------------------------------
package word_counter_pkg;

    localparam int WordWidth = 16;

    localparam logic [1:0] ModeWrap     = 2'b00;
    localparam logic [1:0] ModeSaturate = 2'b01;
    localparam logic [1:0] ModeReload   = 2'b10;
    localparam logic [1:0] ModeOneShot  = 2'b11;

endpackage

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
// Divides enabled cycles down to count ticks: Tick fires on every
// (Prescale+1)-th enabled cycle.
//   Clk_i, Reset_n_i : clock, asynchronous active-low reset
//   Enable           : qualified count enable (already gated by Running)
//   Clear            : synchronous clear; suppresses Tick in the same cycle
//   Prescale         : terminal count
//   Tick             : combinational tick for the current cycle
// -----------------------------------------------------------------------------
module counter_prescaler
    import word_counter_pkg::*;
#(
    parameter int PrescaleWidth = 8
) (
    input  logic                     Clk_i,
    input  logic                     Reset_n_i,
    input  logic                     Enable,
    input  logic                     Clear,
    input  logic [PrescaleWidth-1:0] Prescale,
    output logic                     Tick
);

    logic [PrescaleWidth-1:0] count_r;
    logic                     tick_s;

    // Terminal detect; >= so that lowering Prescale below the running count
    // still yields a tick on the next enabled cycle instead of a long wrap.
    always_comb begin
        if (Enable && !Clear && (count_r >= Prescale)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    assign Tick = tick_s;

    // Prescale counter register.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            count_r <= {PrescaleWidth{1'b0}};
        end else if (Clear) begin
            count_r <= {PrescaleWidth{1'b0}};
        end else if (Enable) begin
            if (tick_s) begin
                count_r <= {PrescaleWidth{1'b0}};
            end else begin
                count_r <= count_r + {{(PrescaleWidth-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/word_counter.sv
// -----------------------------------------------------------------------------
// word_counter
// Up/down counter of WordCount 16-bit words with enable prescaler, four
// terminal-count modes, compare match, sticky overflow/underflow flags and an
// atomic capture register.
//   Clk_i, Reset_n_i     : clock, asynchronous active-low reset
//   ResetSig_i/Preset_i  : synchronous clear / load (ResetSig_i wins)
//   Enable_i, Prescale_i : count enable and prescale terminal
//   Direction_i, Mode_i  : 0 up / 1 down; wrap, saturate, reload, one-shot
//   PresetVal_i          : load and reload value
//   CompareVal_i         : match value for Match_o
//   Capture_i            : snapshot the pre-update value into Capture_o
//   ClearFlags_i         : clears Overflow_o / Underflow_o
//   D_o, Capture_o       : current and captured value
//   Overflow_o, Underflow_o, Zero_o, Match_o, Running_o : status
// -----------------------------------------------------------------------------
module word_counter
    import word_counter_pkg::*;
#(
    parameter int WordCount     = 2,
    parameter int PrescaleWidth = 8
) (
    input  logic                              Clk_i,
    input  logic                              Reset_n_i,
    input  logic                              ResetSig_i,
    input  logic                              Preset_i,
    input  logic                              Enable_i,
    input  logic                              Direction_i,
    input  logic [1:0]                        Mode_i,
    input  logic [WordCount*WordWidth-1:0]    PresetVal_i,
    input  logic [WordCount*WordWidth-1:0]    CompareVal_i,
    input  logic [PrescaleWidth-1:0]          Prescale_i,
    input  logic                              Capture_i,
    input  logic                              ClearFlags_i,
    output logic [WordCount*WordWidth-1:0]    D_o,
    output logic [WordCount*WordWidth-1:0]    Capture_o,
    output logic                              Overflow_o,
    output logic                              Underflow_o,
    output logic                              Zero_o,
    output logic                              Match_o,
    output logic                              Running_o
);

    localparam int W = WordCount * WordWidth;

    localparam logic [W-1:0] ValZero = {W{1'b0}};
    localparam logic [W-1:0] ValMax  = {W{1'b1}};
    localparam logic [W-1:0] ValOne  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] value_r;
    logic [W-1:0] capture_r;
    logic         overflow_r;
    logic         underflow_r;
    logic         match_r;
    logic         running_r;

    logic         tick_s;
    logic         presc_clear_s;
    logic         presc_en_s;
    logic [W-1:0] next_value_s;
    logic         next_running_s;
    logic         ovf_evt_s;
    logic         unf_evt_s;
    logic         match_evt_s;
    logic         terminal_s;
    logic         sat_hold_s;

    assign presc_clear_s = ResetSig_i | Preset_i;
    assign presc_en_s    = Enable_i & running_r;

    counter_prescaler #(
        .PrescaleWidth (PrescaleWidth)
    ) u_prescaler (
        .Clk_i     (Clk_i),
        .Reset_n_i (Reset_n_i),
        .Enable    (presc_en_s),
        .Clear     (presc_clear_s),
        .Prescale  (Prescale_i),
        .Tick      (tick_s)
    );

    // Terminal condition for the current direction and whether saturate holds.
    always_comb begin
        if (Direction_i) begin
            terminal_s = (value_r == ValZero);
        end else begin
            terminal_s = (value_r == ValMax);
        end
        sat_hold_s = terminal_s && (Mode_i == ModeSaturate);
    end

    // Next value, run state, terminal events and match, in priority order.
    always_comb begin
        next_value_s   = value_r;
        next_running_s = running_r;
        ovf_evt_s      = 1'b0;
        unf_evt_s      = 1'b0;
        match_evt_s    = 1'b0;
        if (ResetSig_i) begin
            next_value_s   = ValZero;
            next_running_s = 1'b1;
        end else if (Preset_i) begin
            next_value_s   = PresetVal_i;
            next_running_s = 1'b1;
        end else if (tick_s) begin
            if (terminal_s) begin
                ovf_evt_s = ~Direction_i;
                unf_evt_s = Direction_i;
                case (Mode_i)
                    ModeWrap:     next_value_s = Direction_i ? ValMax : ValZero;
                    ModeSaturate: next_value_s = value_r;
                    ModeReload:   next_value_s = PresetVal_i;
                    ModeOneShot: begin
                        next_value_s   = PresetVal_i;
                        next_running_s = 1'b0;
                    end
                    default:      next_value_s = value_r;
                endcase
            end else if (Direction_i) begin
                next_value_s = value_r - ValOne;
            end else begin
                next_value_s = value_r + ValOne;
            end
            // A saturated hold is not a step, so it never reports a match.
            if ((next_value_s == CompareVal_i) && !sat_hold_s) begin
                match_evt_s = 1'b1;
            end else begin
                match_evt_s = 1'b0;
            end
        end else begin
            next_value_s = value_r;
        end
    end

    // State registers; a terminal event outranks ClearFlags_i for its flag.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            value_r     <= ValZero;
            capture_r   <= ValZero;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            match_r     <= 1'b0;
            running_r   <= 1'b1;
        end else begin
            value_r   <= next_value_s;
            running_r <= next_running_s;
            match_r   <= match_evt_s;
            if (Capture_i) begin
                capture_r <= value_r;
            end else begin
                capture_r <= capture_r;
            end
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end else if (ClearFlags_i) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (unf_evt_s) begin
                underflow_r <= 1'b1;
            end else if (ClearFlags_i) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign D_o         = value_r;
    assign Capture_o   = capture_r;
    assign Overflow_o  = overflow_r;
    assign Underflow_o = underflow_r;
    assign Match_o     = match_r;
    assign Running_o   = running_r;
    assign Zero_o      = (value_r == ValZero);

endmodule

// File: tb/tb_word_counter.sv
// -----------------------------------------------------------------------------
// tb_word_counter
// Directed steps followed by a randomized phase for word_counter
// (WordCount=2, PrescaleWidth=8), checked against a behavioural model that
// tracks the counter as an integer.
// -----------------------------------------------------------------------------
module tb_word_counter;

    localparam int W = 32;
    localparam longint unsigned MAXV = (64'd1 << W) - 64'd1;

    logic          Clk_i = 1'b0;
    logic          Reset_n_i;
    logic          ResetSig_i;
    logic          Preset_i;
    logic          Enable_i;
    logic          Direction_i;
    logic [1:0]    Mode_i;
    logic [W-1:0]  PresetVal_i;
    logic [W-1:0]  CompareVal_i;
    logic [7:0]    Prescale_i;
    logic          Capture_i;
    logic          ClearFlags_i;
    logic [W-1:0]  D_o;
    logic [W-1:0]  Capture_o;
    logic          Overflow_o;
    logic          Underflow_o;
    logic          Zero_o;
    logic          Match_o;
    logic          Running_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    longint unsigned m_val;
    longint unsigned m_cap;
    int              m_presc;
    bit              m_run;
    bit              m_ovf;
    bit              m_unf;
    bit              m_match;

    word_counter #(.WordCount(2), .PrescaleWidth(8)) dut (
        .Clk_i        (Clk_i),
        .Reset_n_i    (Reset_n_i),
        .ResetSig_i   (ResetSig_i),
        .Preset_i     (Preset_i),
        .Enable_i     (Enable_i),
        .Direction_i  (Direction_i),
        .Mode_i       (Mode_i),
        .PresetVal_i  (PresetVal_i),
        .CompareVal_i (CompareVal_i),
        .Prescale_i   (Prescale_i),
        .Capture_i    (Capture_i),
        .ClearFlags_i (ClearFlags_i),
        .D_o          (D_o),
        .Capture_o    (Capture_o),
        .Overflow_o   (Overflow_o),
        .Underflow_o  (Underflow_o),
        .Zero_o       (Zero_o),
        .Match_o      (Match_o),
        .Running_o    (Running_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_cap = 0; m_presc = 0; m_run = 1'b1;
        m_ovf = 1'b0; m_unf = 1'b0; m_match = 1'b0;
    endtask

    // One clock of the counter rules, using the inputs held across the edge.
    task automatic model_step();
        bit tick;
        bit term_up;
        bit term_dn;
        longint unsigned nv;
        tick = 1'b0; term_up = 1'b0; term_dn = 1'b0;
        nv = m_val;
        if (Capture_i) m_cap = m_val;
        m_match = 1'b0;
        if (ResetSig_i) begin
            nv = 0; m_presc = 0; m_run = 1'b1;
        end else if (Preset_i) begin
            nv = PresetVal_i; m_presc = 0; m_run = 1'b1;
        end else begin
            if (Enable_i && m_run) begin
                if (m_presc >= int'(Prescale_i)) begin
                    tick = 1'b1; m_presc = 0;
                end else begin
                    m_presc = m_presc + 1;
                end
            end
            if (tick) begin
                if (!Direction_i && m_val == MAXV) term_up = 1'b1;
                if (Direction_i && m_val == 0) term_dn = 1'b1;
                if (term_up || term_dn) begin
                    if (Mode_i == 2'd0) nv = term_up ? 0 : MAXV;
                    else if (Mode_i == 2'd1) nv = m_val;
                    else nv = PresetVal_i;
                    if (Mode_i == 2'd3) m_run = 1'b0;
                end else begin
                    nv = Direction_i ? m_val - 1 : m_val + 1;
                end
                m_match = (nv == CompareVal_i) && !((term_up || term_dn) && Mode_i == 2'd1);
            end
        end
        m_val = nv;
        if (term_up) m_ovf = 1'b1; else if (ClearFlags_i) m_ovf = 1'b0;
        if (term_dn) m_unf = 1'b1; else if (ClearFlags_i) m_unf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".D"},     D_o,         m_val);
        check({tag, ".cap"},   Capture_o,   m_cap);
        check({tag, ".ovf"},   Overflow_o,  m_ovf);
        check({tag, ".unf"},   Underflow_o, m_unf);
        check({tag, ".zero"},  Zero_o,      m_val == 0);
        check({tag, ".match"}, Match_o,     m_match);
        check({tag, ".run"},   Running_o,   m_run);
    endtask

    task automatic cycle(input string tag);
        @(posedge Clk_i);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] pv;
        Reset_n_i = 1'b0; ResetSig_i = 1'b0; Preset_i = 1'b0; Enable_i = 1'b0;
        Direction_i = 1'b0; Mode_i = 2'd0; PresetVal_i = 32'd0; CompareVal_i = 32'hDEAD_BEEF;
        Prescale_i = 8'd0; Capture_i = 1'b0; ClearFlags_i = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.zero_lit", Zero_o, 1'b1);
        check("reset.run_lit", Running_o, 1'b1);
        Reset_n_i = 1'b1;

        // Wrap up through max
        PresetVal_i = 32'hFFFF_FFFE; Preset_i = 1'b1;
        cycle("wrap.load");
        Preset_i = 1'b0; Enable_i = 1'b1;
        cycle("wrap.t1"); check("wrap.t1_lit", D_o, 32'hFFFF_FFFF);
        cycle("wrap.t2"); check("wrap.t2_lit", D_o, 32'h0000_0000);
        check("wrap.ovf_lit", Overflow_o, 1'b1); check("wrap.zero_lit", Zero_o, 1'b1);
        cycle("wrap.t3"); check("wrap.t3_lit", D_o, 32'h0000_0001);
        Enable_i = 1'b0;

        // Prescale 3 over 12 enabled cycles
        ResetSig_i = 1'b1; cycle("presc.clr"); ResetSig_i = 1'b0;
        ClearFlags_i = 1'b1; cycle("presc.clrf"); ClearFlags_i = 1'b0;
        Prescale_i = 8'd3; Enable_i = 1'b1;
        for (int i = 0; i < 12; i++) cycle("presc.run");
        check("presc.final_lit", D_o, 32'd3);
        Enable_i = 1'b0; Prescale_i = 8'd0;

        // Saturate down from 1
        Mode_i = 2'd1; Direction_i = 1'b1; PresetVal_i = 32'd1; CompareVal_i = 32'd0;
        Preset_i = 1'b1; cycle("sat.load"); Preset_i = 1'b0; Enable_i = 1'b1;
        cycle("sat.t1"); check("sat.t1_match_lit", Match_o, 1'b1); check("sat.t1_unf_lit", Underflow_o, 1'b0);
        cycle("sat.t2"); check("sat.t2_unf_lit", Underflow_o, 1'b1); check("sat.t2_match_lit", Match_o, 1'b0);
        cycle("sat.t3"); check("sat.t3_D_lit", D_o, 32'd0); check("sat.t3_match_lit", Match_o, 1'b0);
        Enable_i = 1'b0;

        // One-shot up
        ClearFlags_i = 1'b1; cycle("os.clrf"); ClearFlags_i = 1'b0;
        Mode_i = 2'd3; Direction_i = 1'b0; PresetVal_i = 32'hFFFF_FFFD;
        Preset_i = 1'b1; cycle("os.load"); Preset_i = 1'b0; Enable_i = 1'b1;
        cycle("os.t1"); check("os.t1_lit", D_o, 32'hFFFF_FFFE);
        cycle("os.t2"); check("os.t2_lit", D_o, 32'hFFFF_FFFF);
        cycle("os.t3"); check("os.t3_lit", D_o, 32'hFFFF_FFFD); check("os.stop_lit", Running_o, 1'b0);
        for (int i = 0; i < 3; i++) cycle("os.idle");
        check("os.idle_lit", D_o, 32'hFFFF_FFFD);
        Preset_i = 1'b1; cycle("os.restart"); Preset_i = 1'b0;
        check("os.restart_lit", Running_o, 1'b1);
        Enable_i = 1'b0;

        // Compare match with capture in the tick cycle
        Mode_i = 2'd0; CompareVal_i = 32'd5; PresetVal_i = 32'd3;
        Preset_i = 1'b1; cycle("cmp.load"); Preset_i = 1'b0; Enable_i = 1'b1;
        cycle("cmp.t1");
        Capture_i = 1'b1; cycle("cmp.t2"); Capture_i = 1'b0; Enable_i = 1'b0;
        check("cmp.match_lit", Match_o, 1'b1); check("cmp.D_lit", D_o, 32'd5);
        check("cmp.cap_lit", Capture_o, 32'd4);
        cycle("cmp.after"); check("cmp.after_lit", Match_o, 1'b0);

        // Wrap event with ClearFlags in the same cycle
        ClearFlags_i = 1'b1; cycle("clrwrap.pre"); ClearFlags_i = 1'b0;
        PresetVal_i = 32'hFFFF_FFFF; Preset_i = 1'b1; cycle("clrwrap.load"); Preset_i = 1'b0;
        Enable_i = 1'b1; ClearFlags_i = 1'b1; cycle("clrwrap.evt");
        check("clrwrap.ovf_lit", Overflow_o, 1'b1);
        Enable_i = 1'b0; cycle("clrwrap.clr"); ClearFlags_i = 1'b0;
        check("clrwrap.cleared_lit", Overflow_o, 1'b0);

        // ResetSig_i beats Preset_i
        PresetVal_i = 32'h0000_1234; Preset_i = 1'b1; ResetSig_i = 1'b1;
        cycle("prio"); check("prio.D_lit", D_o, 32'd0);
        Preset_i = 1'b0; ResetSig_i = 1'b0;

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            ResetSig_i = (r < 2);
            Preset_i = (r >= 2 && r < 8);
            Enable_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) Direction_i = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) Mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) Prescale_i = 8'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: pv = 32'h0000_0000;
                1: pv = 32'hFFFF_FFFF;
                2: pv = 32'hFFFF_FFFE;
                default: pv = $urandom;
            endcase
            PresetVal_i = pv;
            CompareVal_i = 32'(m_val) + 32'($urandom_range(0, 4)) - 32'd2;
            Capture_i = ($urandom_range(0, 3) == 0);
            ClearFlags_i = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end
        ResetSig_i = 1'b0; Preset_i = 1'b0; Capture_i = 1'b0; ClearFlags_i = 1'b0;

        // Asynchronous reset mid-count
        Mode_i = 2'd0; Direction_i = 1'b0; Prescale_i = 8'd0; PresetVal_i = 32'h0000_0100;
        Preset_i = 1'b1; cycle("arst.load"); Preset_i = 1'b0; Enable_i = 1'b1;
        Capture_i = 1'b1; cycle("arst.c1"); Capture_i = 1'b0;
        cycle("arst.c2");
        #2; Reset_n_i = 1'b0; #1;
        model_reset();
        check_all("arst");
        check("arst.D_lit", D_o, 32'd0);
        check("arst.cap_lit", Capture_o, 32'd0);
        #2; Reset_n_i = 1'b1;
        cycle("arst.resume");
        Enable_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/word_counter.md
# word_counter

Parametrised up/down counter, successor to the fixed 32-bit counter cell in the WSN-SoC cell library. Width is a multiple of 16-bit words for direct attachment to the Word interconnect. Adds the following over the fixed cell:
- enable prescaler;
- four terminal-count modes (wrap, saturate, auto-reload, one-shot);
- compare match;
- separate sticky overflow/underflow flags;
- atomic multi-word capture register.

## Interface
- WordCount, 2, number of 16-bit words; counter width W = 16*WordCount (1..4)
- PrescaleWidth, 8, width of prescaler counter and Prescale_i
- Reset_n_i  in  1  asynchronous active-low reset
- Clk_i  in  1  clock, rising edge
- ResetSig_i  in  1  synchronous clear of value and prescaler
- Preset_i  in  1  synchronous load of PresetVal_i
- Enable_i  in  1  count enable, feeds prescaler
- Direction_i  in  1  0 = up, 1 = down
- Mode_i  in  2  00 wrap, 01 saturate, 10 auto-reload, 11 one-shot
- PresetVal_i  in  W  load/reload value
- CompareVal_i  in  W  match value
- Prescale_i  in  PrescaleWidth  tick every Prescale_i+1 enabled cycles
- Capture_i  in  1  snapshot request
- ClearFlags_i  in  1  clears Overflow_o, Underflow_o
- D_o  out  W  current value
- Capture_o  out  W  last captured value
- Overflow_o  out  1  sticky, up-count terminal event seen
- Underflow_o  out  1  sticky, down-count terminal event seen
- Zero_o  out  1  D_o == 0
- Match_o  out  1  one-cycle pulse, value stepped onto CompareVal_i
- Running_o  out  1  0 while one-shot has expired

## Operation
- Prescaler:
  - Counts cycles with Enable_i=1 && Running_o=1.
  - Tick when prescaler == Prescale_i; prescaler then returns to 0.
  - Prescale_i=0 ticks every enabled cycle.
  - Prescale_i lowered below the current count: terminal compare uses >=, so a tick occurs on the next enabled cycle.
- Priority per cycle: ResetSig_i > Preset_i > tick.
  - ResetSig_i: value=0, prescaler=0, Running=1; no tick.
  - Preset_i: value=PresetVal_i, prescaler=0, Running=1; no tick.
- Tick, up, value < max (2^W-1): value+1.
- Tick, up, value == max; Overflow_o set in every mode:
  - wrap: value=0.
  - saturate: value held at max.
  - auto-reload: value=PresetVal_i.
  - one-shot: value=PresetVal_i and Running=0.
- Tick, down, value == 0: same four cases with Underflow_o. Wrap goes to max; saturate holds 0; reload/one-shot load PresetVal_i.
- Flags:
  - Set by the terminal event only, never by Preset/ResetSig.
  - ClearFlags_i clears both flags.
  - A terminal event in the same cycle as ClearFlags_i leaves its flag set.
- Match_o:
  - High for exactly one cycle after a tick whose new value == CompareVal_i.
  - Not asserted for Preset/ResetSig loads.
  - Not asserted while the value is held by saturate.
- Capture_i: Capture_o = value before that cycle's update, so all words are coherent.
- Zero_o: combinational compare of the registered value.

## Timing
- Reset values: D_o=0, Capture_o=0, Overflow_o=0, Underflow_o=0, Match_o=0, Zero_o=1, Running_o=1, prescaler=0.
- All state updates on the rising Clk_i edge; value visible on D_o one cycle after the causing input.
- Flags and Match_o update in the same edge as the value.
- Mode_i, Direction_i, PresetVal_i, CompareVal_i are sampled at the tick edge; they may change at any time.
- Reset_n_i asserted mid-count forces all reset values immediately, independent of Clk_i.

## Structure
- Package word_counter_pkg: mode constants ModeWrap, ModeSaturate, ModeReload, ModeOneShot (2-bit), and the word width constant 16.
- Sub-module counter_prescaler:
  - Parameter PrescaleWidth.
  - Inputs Enable, Clear, Prescale.
  - Output Tick.
- The top holds the value register, mode logic, flags and capture register.

## Test plan
- WordCount=2, Prescale_i=0, up, wrap, Preset 0xFFFFFFFE, enable 3 cycles -> D_o FFFFFFFF, 00000000 (Overflow_o=1, Zero_o=1), 00000001.
- Prescale_i=3, up, from 0, Enable_i held 12 cycles -> D_o increments to 3, one step every 4th enabled cycle.
- Saturate down from 1, 3 ticks -> D_o 0, 0, 0; Underflow_o set on the second tick; Match_o never pulses with CompareVal=0 after the first tick.
- One-shot up, PresetVal=0xFFFFFFFD, enabled -> D_o FFFFFFFE, FFFFFFFF, then 0xFFFFFFFD with Running_o=0; further enable cycles leave D_o unchanged; Preset_i restarts with Running_o=1.
- CompareVal=5, count up from 3, Capture_i in the tick cycle to 5 -> Match_o one cycle high with D_o=5; Capture_o=4.
- Wrap event coinciding with ClearFlags_i -> Overflow_o=1. ResetSig_i with Preset_i -> D_o=0. Reset_n_i low mid-count -> all reset values immediately.
